// File: rtl/pwm_level_decoder.sv
// Recovers the level of a bit-reversed PWM stream by counting high samples
// over a fixed window of 2^WIDTH clocks.
module pwm_level_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit INVERT      = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic             valid,
    output logic             stable,
    output logic [WIDTH:0]   high_count
);

    localparam logic [WIDTH-1:0] TERM = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES:0]   sync_ext;
    logic                   s;

    logic [WIDTH-1:0] win_q;
    logic [WIDTH-1:0] win_d;
    logic [WIDTH:0]   ones_q;
    logic [WIDTH:0]   ones_d;
    logic [WIDTH:0]   total;
    logic             term;

    logic [WIDTH-1:0] lvl_q;
    logic [WIDTH-1:0] lvl_d;
    logic [WIDTH-1:0] new_lvl;
    logic [WIDTH:0]   hc_q;
    logic [WIDTH:0]   hc_d;
    logic             valid_q;
    logic             valid_d;
    logic             stable_q;
    logic             stable_d;
    logic             have_q;
    logic             have_d;

    assign sync_ext = {sync_q, pwm_in};
    assign sync_d   = sync_ext[SYNC_STAGES-1:0];
    assign s        = sync_q[SYNC_STAGES-1];

    assign term  = (win_q == TERM);
    assign total = ones_q + {{WIDTH{1'b0}}, s};

    // A full window of ones (total = 2^WIDTH) needs its own mapping.
    always_comb begin
        new_lvl = total[WIDTH-1:0];
        if (INVERT) begin
            new_lvl = total[WIDTH] ? '0 : ~total[WIDTH-1:0];
        end else begin
            new_lvl = total[WIDTH] ? '1 : total[WIDTH-1:0];
        end
    end

    always_comb begin
        win_d    = win_q;
        ones_d   = ones_q;
        lvl_d    = lvl_q;
        hc_d     = hc_q;
        valid_d  = 1'b0;
        stable_d = stable_q;
        have_d   = have_q;
        if (!enable) begin
            win_d  = '0;
            ones_d = '0;
        end else begin
            win_d  = win_q + 1'b1;
            ones_d = total;
            if (term) begin
                ones_d   = '0;
                hc_d     = total;
                lvl_d    = new_lvl;
                valid_d  = 1'b1;
                stable_d = have_q && (new_lvl == lvl_q);
                have_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            win_q    <= '0;
            ones_q   <= '0;
            lvl_q    <= '0;
            hc_q     <= '0;
            valid_q  <= 1'b0;
            stable_q <= 1'b0;
            have_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            win_q    <= win_d;
            ones_q   <= ones_d;
            lvl_q    <= lvl_d;
            hc_q     <= hc_d;
            valid_q  <= valid_d;
            stable_q <= stable_d;
            have_q   <= have_d;
        end
    end

    assign level      = lvl_q;
    assign valid      = valid_q;
    assign stable     = stable_q;
    assign high_count = hc_q;

endmodule
